lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the ALU stage; consumes the ALU result as the effective address when a memory instruction executes.
- Issues one data-memory request per instruction over a valid/ready request channel and a valid-only response channel.
- Aligns and extends load data, and produces the writeback value plus a done pulse for the WBU.
- Non-memory instructions pass the ALU result through with one cycle of latency.

Parameters:
- ADDR_W, 32, width of address and ALU result.
- DATA_W, 32, data-memory word width; fixed at 32 for byte-lane logic.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ALU_done  in  1  ALU result valid; one-cycle pulse per instruction.
- alu_result  in  ADDR_W  effective address, or pass-through value.
- store_data  in  32  rs2 value for stores.
- mem_op  in  4  [3]=is_mem, [2]=is_store, [1:0]=size (00 byte, 01 half, 10 word).
- load_unsigned  in  1  1 = zero-extend (lbu/lhu).
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wen  out  1  1 = write.
- mem_req_addr  out  ADDR_W  word-aligned address (low 2 bits zero).
- mem_req_wdata  out  32  lane-shifted store data.
- mem_req_wmask  out  4  byte enables.
- mem_rsp_valid  in  1  response valid; arrives for both reads and writes.
- mem_rsp_rdata  in  32  read word.
- lsu_result  out  32  writeback value.
- LSU_done  out  1  one-cycle pulse; lsu_result is valid this cycle.
- misalign  out  1  one-cycle pulse alongside LSU_done on a misaligned access (feature only).

Behaviour:
- Reset values, asynchronous:
  - state=IDLE.
  - All outputs 0: mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask, lsu_result, LSU_done, misalign.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On ALU_done with mem_op[3]=0: latch lsu_result=alu_result and pulse LSU_done the next cycle (latency 1); remain in IDLE.
  - On ALU_done with mem_op[3]=1: latch the address, offset (alu_result[1:0]), size, store flag, unsigned flag and store_data; go to REQ.
  - ALU_done while not in IDLE is ignored. Upstream guarantees it does not happen; the bench asserts it.
- REQ:
  - mem_req_valid=1, with addr/wen/wdata/wmask stable until mem_req_ready.
  - On valid&&ready: go to WAIT and drop mem_req_valid the next cycle.
  - A response in the same cycle as ready is not allowed.
- WAIT:
  - On mem_rsp_valid: for loads, compute lsu_result; for stores, set lsu_result=0. Go to DONE.
- DONE: LSU_done=1 for exactly one cycle, then IDLE.
- Minimum memory-op latency from ALU_done to LSU_done is 3 cycles.
- Store lanes, with offset o:
  - Byte: wmask=4'b0001<<o, wdata=store_data[7:0] replicated across 4 lanes.
  - Half: wmask=4'b0011<<o, wdata=store_data[15:0] replicated twice.
  - Word: wmask=4'b1111, wdata=store_data.
- Load extraction:
  - Byte: rdata[8o+7:8o].
  - Half: rdata[8o+15:8o].
  - Sign-extend unless load_unsigned; word loads ignore load_unsigned.
- Size 11 is treated as word.
- Misaligned access (half with o=3 or o=1 counts only o odd; word with o!=0):
  - Without the feature: the address is forced aligned, and the mask/shift use o truncated to the legal lanes: half uses o&2, word uses 0.
- Reset mid-transaction returns to IDLE immediately and drops mem_req_valid; a late mem_rsp_valid seen in IDLE is ignored.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access issues no memory request; go directly to DONE.
  - lsu_result=alu_result (faulting address), with misalign=1 alongside LSU_done.
- Undefined: the misalign port is tied to 0 and the truncation rule above applies.

Decomposition:
- Shared package:
  - lsu_state_e (IDLE/REQ/WAIT/DONE).
  - Size encodings SZ_B/SZ_H/SZ_W.
  - mem_op bit-position constants.
- One natural sub-module: lsu_align, a combinational block computing wmask/wdata from size+offset and load extraction/extension from rdata+offset+size+unsigned.

Test Plan:
- Pass-through: ALU_done, mem_op=0, alu_result=0x1234 -> LSU_done next cycle, lsu_result=0x1234, no mem_req_valid.
- lb: addr 0x1003, rdata=0x80FF_0000 -> req addr 0x1000, wen=0, lsu_result=0xFFFFFF80; repeat with lbu -> 0x00000080.
- sh: addr 0x2002, store_data=0xDEADBEEF -> wmask=4'b1100, wdata=0xBEEFBEEF, lsu_result=0.
- Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid held, addr/wdata stable; LSU_done 1 cycle after the response.
- rst asserted in WAIT -> all outputs 0 that cycle; a subsequent stray mem_rsp_valid produces no LSU_done.
- With LSU_MISALIGN_TRAP_EN: lw at 0x3001 -> no request, LSU_done=1 with misalign=1, lsu_result=0x3001; without the macro, a request at 0x3000 with wmask=4'b1111.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e    : control FSM states (IDLE/REQ/WAIT/DONE)
//   SZ_B/SZ_H/SZ_W : access size encodings carried in mem_op[1:0]
//   OP_*           : bit positions inside mem_op
//   is_misaligned  : alignment test for a size/offset pair
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned OP_IS_MEM   = 3;
  localparam int unsigned OP_IS_STORE = 2;
  localparam int unsigned OP_SIZE_HI  = 1;
  localparam int unsigned OP_SIZE_LO  = 0;

  // Halves only need an even offset; words (and the size-11 alias) need offset 0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align: combinational byte-lane logic for the load/store unit.
//   size_i       : access size (SZ_B/SZ_H/SZ_W, 11 treated as word)
//   offset_i     : byte offset within the word (address bits [1:0])
//   unsigned_i   : zero-extend sub-word loads when 1
//   store_data_i : rs2 value to be placed on the write lanes
//   rdata_i      : memory read word
//   wmask_o      : byte enables
//   wdata_o      : lane-replicated write data
//   load_data_o  : extracted and extended load value
// Misaligned offsets are truncated to the legal lanes (half uses o&2, word 0).
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [1:0]  eff_off_s;
  logic [31:0] shifted_s;

  // Effective offset, store lanes and load extraction for the given size.
  always_comb begin
    eff_off_s   = 2'b00;
    wmask_o     = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = rdata_i;
    case (size_i)
      SZ_B: begin
        eff_off_s = offset_i;
        wmask_o   = 4'b0001 << eff_off_s;
        wdata_o   = {4{store_data_i[7:0]}};
      end
      SZ_H: begin
        eff_off_s = {offset_i[1], 1'b0};
        wmask_o   = 4'b0011 << eff_off_s;
        wdata_o   = {2{store_data_i[15:0]}};
      end
      default: begin
        eff_off_s = 2'b00;
        wmask_o   = 4'b1111;
        wdata_o   = store_data_i;
      end
    endcase
    // Bring the addressed lane down to bit 0 before extending.
    shifted_s = rdata_i >> {eff_off_s, 3'b000};
    case (size_i)
      SZ_B:    load_data_o = unsigned_i ? {24'h000000, shifted_s[7:0]}
                                        : {{24{shifted_s[7]}}, shifted_s[7:0]};
      SZ_H:    load_data_o = unsigned_i ? {16'h0000, shifted_s[15:0]}
                                        : {{16{shifted_s[15]}}, shifted_s[15:0]};
      default: load_data_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu: load/store unit downstream of the ALU.
//   clk, rst           : clock, asynchronous active-high reset
//   ALU_done           : ALU result valid pulse
//   alu_result         : effective address or pass-through value
//   store_data         : rs2 value for stores
//   mem_op             : [3]=is_mem [2]=is_store [1:0]=size
//   load_unsigned      : zero-extend sub-word loads
//   mem_req_*          : valid/ready data-memory request channel (registered)
//   mem_rsp_valid/rdata: valid-only response channel
//   lsu_result         : writeback value, valid while LSU_done
//   LSU_done           : one-cycle completion pulse
//   misalign           : misaligned-access flag alongside LSU_done
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, a misaligned
// access skips the memory and completes with the faulting address and
// misalign=1. When undefined, misalign stays 0 and offsets are truncated.
// -----------------------------------------------------------------------------
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ALU_done,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [31:0]       store_data,
  input  logic [3:0]        mem_op,
  input  logic              load_unsigned,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata,
  output logic [DATA_W-1:0] lsu_result,
  output logic              LSU_done,
  output logic              misalign
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN_C = 1'b1;
`else
  localparam logic TRAP_EN_C = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic [1:0]        off_q, off_d, size_q, size_d;
  logic              store_q, store_d, uns_q, uns_d;
  logic              valid_q, valid_d, wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d, mis_q, mis_d;

  logic [1:0]  size_s, off_s;
  logic        uns_s, trap_s;
  logic [3:0]  wmask_s;
  logic [31:0] wdata_s, load_s;

  // Align logic sees the live instruction in IDLE and the latched one afterwards.
  always_comb begin
    if (state_q == IDLE) begin
      size_s = mem_op[OP_SIZE_HI:OP_SIZE_LO];
      off_s  = alu_result[1:0];
      uns_s  = load_unsigned;
    end else begin
      size_s = size_q;
      off_s  = off_q;
      uns_s  = uns_q;
    end
  end

  assign trap_s = TRAP_EN_C & is_misaligned(mem_op[OP_SIZE_HI:OP_SIZE_LO], alu_result[1:0]);

  lsu_align u_align (
    .size_i      (size_s),
    .offset_i    (off_s),
    .unsigned_i  (uns_s),
    .store_data_i(store_data),
    .rdata_i     (mem_rsp_rdata),
    .wmask_o     (wmask_s),
    .wdata_o     (wdata_s),
    .load_data_o (load_s)
  );

  // Next-state and registered-output logic; done/misalign default to a pulse.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    size_d   = size_q;
    store_d  = store_q;
    uns_d    = uns_q;
    valid_d  = valid_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    result_d = result_q;
    done_d   = 1'b0;
    mis_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ALU_done) begin
          if (!mem_op[OP_IS_MEM]) begin
            result_d = DATA_W'(alu_result);
            done_d   = 1'b1;
          end else if (trap_s) begin
            result_d = DATA_W'(alu_result);
            done_d   = 1'b1;
            mis_d    = 1'b1;
            state_d  = DONE;
          end else begin
            off_d   = alu_result[1:0];
            size_d  = mem_op[OP_SIZE_HI:OP_SIZE_LO];
            store_d = mem_op[OP_IS_STORE];
            uns_d   = load_unsigned;
            valid_d = 1'b1;
            wen_d   = mem_op[OP_IS_STORE];
            addr_d  = {alu_result[ADDR_W-1:2], 2'b00};
            wdata_d = wdata_s;
            wmask_d = wmask_s;
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          valid_d = 1'b0;
          state_d = WAIT;
        end else begin
          valid_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          result_d = store_q ? {DATA_W{1'b0}} : load_s;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      off_q    <= 2'b00;
      size_q   <= 2'b00;
      store_q  <= 1'b0;
      uns_q    <= 1'b0;
      valid_q  <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= 32'h0000_0000;
      wmask_q  <= 4'b0000;
      result_q <= {DATA_W{1'b0}};
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      size_q   <= size_d;
      store_q  <= store_d;
      uns_q    <= uns_d;
      valid_q  <= valid_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      result_q <= result_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
    end
  end

  assign mem_req_valid = valid_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign lsu_result    = result_q;
  assign LSU_done      = done_q;
  assign misalign      = mis_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ALU_done = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [3:0]  mem_op = 4'h0;
  logic        load_unsigned = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = 32'h0;
  logic [31:0] lsu_result;
  logic        LSU_done;
  logic        misalign;

  lsu dut (
    .clk(clk), .rst(rst), .ALU_done(ALU_done), .alu_result(alu_result),
    .store_data(store_data), .mem_op(mem_op), .load_unsigned(load_unsigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .lsu_result(lsu_result), .LSU_done(LSU_done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic        uns;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    logic [31:0] e_res;
  } vec_t;

  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;
  logic in_flight = 1'b0;

  // ALU_done is only ever presented while no instruction is outstanding.
  always @(posedge clk) begin
    if (ALU_done) assert (!in_flight) else $error("ALU_done issued while busy");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, ".valid"},  mem_req_valid, 32'h0);
    chk({nm, ".wen"},    mem_req_wen,   32'h0);
    chk({nm, ".addr"},   mem_req_addr,  32'h0);
    chk({nm, ".wdata"},  mem_req_wdata, 32'h0);
    chk({nm, ".wmask"},  mem_req_wmask, 32'h0);
    chk({nm, ".result"}, lsu_result,    32'h0);
    chk({nm, ".done"},   LSU_done,      32'h0);
    chk({nm, ".mis"},    misalign,      32'h0);
  endtask

  // Present one instruction; returns just after the capturing clock edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic uns);
    @(negedge clk);
    ALU_done = 1'b1; mem_op = op; alu_result = a; store_data = sd; load_unsigned = uns;
    @(negedge clk);
    ALU_done = 1'b0; mem_op = 4'h0; alu_result = 32'h0; store_data = 32'h0; load_unsigned = 1'b0;
    in_flight = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    string nm;
    v  = vecs[i];
    nm = $sformatf("vec%0d", i);
    issue(v.op, v.addr, v.sd, v.uns);
    if (!v.op[3]) begin
      chk({nm, ".done"},   LSU_done,      32'h1);
      chk({nm, ".result"}, lsu_result,    v.e_res);
      chk({nm, ".valid"},  mem_req_valid, 32'h0);
    end else begin
      chk({nm, ".valid"}, mem_req_valid, 32'h1);
      chk({nm, ".addr"},  mem_req_addr,  v.e_addr);
      chk({nm, ".wen"},   mem_req_wen,   {31'h0, v.e_wen});
      chk({nm, ".wdata"}, mem_req_wdata, v.e_wdata);
      chk({nm, ".wmask"}, mem_req_wmask, {28'h0, v.e_wmask});
      chk({nm, ".early"}, LSU_done,      32'h0);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk({nm, ".drop"}, mem_req_valid, 32'h0);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = v.rdata;
      @(negedge clk);
      mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
      chk({nm, ".done"},   LSU_done,   32'h1);
      chk({nm, ".result"}, lsu_result, v.e_res);
      chk({nm, ".mis"},    misalign,   32'h0);
    end
    @(negedge clk);
    chk({nm, ".pulse"}, LSU_done, 32'h0);
    in_flight = 1'b0;
  endtask

  initial begin
    //          op       addr          sd            uns   rdata         e_addr        wen   e_wdata       wmask    e_res
    vecs[0]  = '{4'b0000, 32'h0000_1234, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0000, 32'h0000_1234};
    vecs[1]  = '{4'b1000, 32'h0000_1003, 32'h0,        1'b0, 32'h80FF_0000, 32'h0000_1000, 1'b0, 32'h0,        4'b1000, 32'hFFFF_FF80};
    vecs[2]  = '{4'b1000, 32'h0000_1003, 32'h0,        1'b1, 32'h80FF_0000, 32'h0000_1000, 1'b0, 32'h0,        4'b1000, 32'h0000_0080};
    vecs[3]  = '{4'b1101, 32'h0000_2002, 32'hDEAD_BEEF, 1'b0, 32'hFFFF_FFFF, 32'h0000_2000, 1'b1, 32'hBEEF_BEEF, 4'b1100, 32'h0};
    vecs[4]  = '{4'b1001, 32'h0000_2002, 32'h0,        1'b0, 32'h80FF_0000, 32'h0000_2000, 1'b0, 32'h0,        4'b1100, 32'hFFFF_80FF};
    vecs[5]  = '{4'b1001, 32'h0000_4000, 32'h0,        1'b1, 32'h1234_8765, 32'h0000_4000, 1'b0, 32'h0,        4'b0011, 32'h0000_8765};
    vecs[6]  = '{4'b1100, 32'h0000_5001, 32'h0000_00A5, 1'b0, 32'hFFFF_FFFF, 32'h0000_5000, 1'b1, 32'hA5A5_A5A5, 4'b0010, 32'h0};
    vecs[7]  = '{4'b1110, 32'h0000_6004, 32'hCAFE_F00D, 1'b0, 32'hFFFF_FFFF, 32'h0000_6004, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0};
    vecs[8]  = '{4'b1010, 32'h0000_7008, 32'h0,        1'b1, 32'h89AB_CDEF, 32'h0000_7008, 1'b0, 32'h0,        4'b1111, 32'h89AB_CDEF};
    vecs[9]  = '{4'b1011, 32'h0000_700C, 32'h0,        1'b0, 32'h8000_0001, 32'h0000_700C, 1'b0, 32'h0,        4'b1111, 32'h8000_0001};
    vecs[10] = '{4'b1000, 32'h0000_1001, 32'h0,        1'b0, 32'h0000_7F00, 32'h0000_1000, 1'b0, 32'h0,        4'b0010, 32'h0000_007F};
    vecs[11] = '{4'b0000, 32'hFFFF_FFFF, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0000, 32'hFFFF_FFFF};

    // Reset state.
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i);

    // Backpressure: request held stable for 5 stalled cycles.
    issue(4'b1110, 32'h0000_8000, 32'h1122_3344, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d.valid", k), mem_req_valid, 32'h1);
      chk($sformatf("bp%0d.addr", k),  mem_req_addr,  32'h0000_8000);
      chk($sformatf("bp%0d.wdata", k), mem_req_wdata, 32'h1122_3344);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("bp.drop", mem_req_valid, 32'h0);
    @(negedge clk);
    chk("bp.wait", LSU_done, 32'h0);
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("bp.done",   LSU_done,   32'h1);
    chk("bp.result", lsu_result, 32'h0);
    @(negedge clk);
    chk("bp.pulse", LSU_done, 32'h0);
    in_flight = 1'b0;

    // Reset while waiting for the response, then a stray response.
    issue(4'b1010, 32'h0000_9000, 32'h0, 1'b0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_idle_outputs("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    in_flight = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
    chk("stray.done0", LSU_done, 32'h0);
    @(negedge clk);
    chk("stray.done1",  LSU_done,      32'h0);
    chk("stray.valid",  mem_req_valid, 32'h0);
    chk("stray.result", lsu_result,    32'h0);

    // Misaligned word load at 0x3001.
    issue(4'b1010, 32'h0000_3001, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis.valid",  mem_req_valid, 32'h0);
    chk("mis.done",   LSU_done,      32'h1);
    chk("mis.flag",   misalign,      32'h1);
    chk("mis.result", lsu_result,    32'h0000_3001);
    @(negedge clk);
    chk("mis.pulse", LSU_done, 32'h0);
    chk("mis.flag0", misalign, 32'h0);
`else
    chk("mis.valid", mem_req_valid, 32'h1);
    chk("mis.addr",  mem_req_addr,  32'h0000_3000);
    chk("mis.wmask", mem_req_wmask, 32'hF);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5566_7788;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
    chk("mis.done",   LSU_done,   32'h1);
    chk("mis.flag",   misalign,   32'h0);
    chk("mis.result", lsu_result, 32'h5566_7788);
    @(negedge clk);
    chk("mis.pulse", LSU_done, 32'h0);
`endif
    in_flight = 1'b0;

`ifndef LSU_MISALIGN_TRAP_EN
    // Misaligned half store at offset 3 uses the upper half lanes.
    issue(4'b1101, 32'h0000_2003, 32'h0000_ABCD, 1'b0);
    chk("mish.addr",  mem_req_addr,  32'h0000_2000);
    chk("mish.wmask", mem_req_wmask, 32'hC);
    chk("mish.wdata", mem_req_wdata, 32'hABCD_ABCD);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("mish.done", LSU_done, 32'h1);
    @(negedge clk);
    in_flight = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
